// File: rtl/merge_table_resolver.sv
// Connected-components merge resolver: drains equivalence pairs, unions them,
// flattens the label table and serves registered root lookups.
module merge_table_resolver #(
   parameter int WORD_SIZE = 8,
   parameter int DEPTH     = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_done,
   input  logic                   clear,
   input  logic [WORD_SIZE-1:0]   num_labels,
   input  logic [2*WORD_SIZE-1:0] stack_top,
   input  logic                   empty,
   output logic                   pop,
   output logic                   busy,
   output logic                   done,
   output logic [WORD_SIZE-1:0]   n_objects,
   input  logic [WORD_SIZE-1:0]   lookup_label,
   output logic [WORD_SIZE-1:0]   resolved_label
);

   localparam int W = WORD_SIZE;

   typedef enum logic [2:0] {
      S_INIT, S_READY, S_DRAIN, S_FIND_A,
      S_FIND_B, S_LINK, S_FLATTEN, S_DONE
   } state_t;

   state_t       r_state;
   logic [W:0]   r_idx;
   logic [W:0]   r_cnt;
   logic [W-1:0] r_num;
   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic         r_busy;
   logic         r_done;
   logic [W-1:0] r_nobj;
   logic [W-1:0] r_res;
   logic [W-1:0] r_table [DEPTH];

   logic [W-1:0] w_idx;
   logic [W-1:0] w_hi;
   logic [W-1:0] w_lo;
   logic [W-1:0] w_ta;
   logic [W-1:0] w_tb;
   logic [W-1:0] w_ti;
   logic [W-1:0] w_tti;
   logic         w_degen;
   logic         w_last;
   logic         w_root;
   logic [W:0]   w_cnt_nxt;
   logic [W-1:0] w_nobj;
   logic         w_we;
   logic [W-1:0] w_waddr;
   logic [W-1:0] w_wdata;

   assign w_idx     = r_idx[W-1:0];
   assign w_hi      = stack_top[2*W-1:W];
   assign w_lo      = stack_top[W-1:0];
   assign w_ta      = r_table[r_a];
   assign w_tb      = r_table[r_b];
   assign w_ti      = r_table[w_idx];
   assign w_tti     = r_table[w_ti];
   assign w_degen   = (w_hi == w_lo) || (w_hi == '0) || (w_lo == '0) ||
                      (w_hi >= r_num) || (w_lo >= r_num);
   assign w_last    = (r_idx == ({1'b0, r_num} - 1'b1));
   assign w_root    = (w_ti == w_idx);
   assign w_cnt_nxt = r_cnt + {{W{1'b0}}, w_root};
   assign w_nobj    = w_cnt_nxt[W] ? '1 : w_cnt_nxt[W-1:0];

   assign pop            = (r_state == S_DRAIN) && !empty;
   assign busy           = r_busy;
   assign done           = r_done;
   assign n_objects      = r_nobj;
   assign resolved_label = r_res;

   always_comb begin
      w_we    = 1'b0;
      w_waddr = w_idx;
      w_wdata = w_idx;
      case (r_state)
         S_INIT: w_we = 1'b1;
         S_LINK: begin
            w_we    = (r_a != r_b);
            w_waddr = (r_a > r_b) ? r_a : r_b;
            w_wdata = (r_a > r_b) ? r_b : r_a;
         end
         S_FLATTEN: begin
            w_we    = 1'b1;
            w_wdata = w_tti;
         end
         default: ;
      endcase
   end

   // Table holds no reset: INIT rewrites every entry after reset.
   always_ff @(posedge clk) begin
      if (w_we)
         r_table[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_res <= '0;
      else
         r_res <= (lookup_label == '0) ? '0 : r_table[lookup_label];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_INIT;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_num   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
         r_nobj  <= '0;
      end else begin
         case (r_state)
            S_INIT: begin
               if (r_idx == (DEPTH - 1)) begin
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_READY;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_READY: begin
               if (frame_done) begin
                  r_num   <= num_labels;
                  r_busy  <= 1'b1;
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (empty) begin
                  r_idx <= {{W{1'b0}}, 1'b1};
                  r_cnt <= '0;
                  if (r_num <= 1) begin
                     r_nobj  <= '0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_FLATTEN;
                  end
               end else begin
                  r_a <= w_hi;
                  r_b <= w_lo;
                  if (!w_degen)
                     r_state <= S_FIND_A;
               end
            end
            S_FIND_A: begin
               if (w_ta == r_a)
                  r_state <= S_FIND_B;
               else
                  r_a <= w_ta;
            end
            S_FIND_B: begin
               if (w_tb == r_b)
                  r_state <= S_LINK;
               else
                  r_b <= w_tb;
            end
            S_LINK: r_state <= S_DRAIN;
            S_FLATTEN: begin
               r_cnt <= w_cnt_nxt;
               if (w_last) begin
                  r_nobj  <= w_nobj;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               if (clear) begin
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_state <= S_INIT;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_merge_table_resolver.sv
// Directed bench for merge_table_resolver with a queue-based merge stack model.
module tb_merge_table_resolver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_done = 1'b0;
   logic        clear = 1'b0;
   logic [7:0]  num_labels = '0;
   logic [15:0] stack_top = '0;
   logic        empty = 1'b1;
   logic        pop;
   logic        busy;
   logic        done;
   logic [7:0]  n_objects;
   logic [7:0]  lookup_label = '0;
   logic [7:0]  resolved_label;

   int checks = 0;
   int failures = 0;
   int pop_total = 0;
   int pops_start;
   int cyc;
   logic [15:0] stk [$];

   always #5 clk = ~clk;

   merge_table_resolver #(.WORD_SIZE(8), .DEPTH(256)) dut (
      .clk(clk),
      .reset(reset),
      .frame_done(frame_done),
      .clear(clear),
      .num_labels(num_labels),
      .stack_top(stack_top),
      .empty(empty),
      .pop(pop),
      .busy(busy),
      .done(done),
      .n_objects(n_objects),
      .lookup_label(lookup_label),
      .resolved_label(resolved_label)
   );

   // Stack model: front of the queue is the top entry.
   always @(posedge clk) begin
      if (reset) begin
         stk.delete();
      end else if (pop && stk.size() > 0) begin
         void'(stk.pop_front());
         pop_total++;
      end
      empty <= (stk.size() == 0);
      stack_top <= (stk.size() > 0) ? stk[0] : 16'h0;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_init_cycles"}, n, 256);
      chk({tag, "_ready_busy"}, busy, 0);
   endtask

   task automatic look(input string tag, input logic [7:0] lbl,
                       input logic [7:0] exp);
      @(negedge clk);
      lookup_label = lbl;
      @(posedge clk);
      #1;
      chk(tag, resolved_label, exp);
   endtask

   task automatic run_frame(input logic [7:0] num);
      int n;
      num_labels = num;
      repeat (2) @(negedge clk);
      pops_start = pop_total;
      frame_done = 1'b1;
      @(posedge clk);
      #1;
      frame_done = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      cyc = n;
      chk("frame_done_reached", done, 1);
      chk("frame_busy_low", busy, 0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      chk("clear_busy", busy, 1);
      wait_ready("clear");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_pop", pop, 0);
      chk("rst_busy", busy, 1);
      chk("rst_done", done, 0);
      chk("rst_nobj", n_objects, 0);
      chk("rst_res", resolved_label, 0);
      reset = 1'b0;
      wait_ready("rst");
      look("ready_lookup7", 8'd7, 8'd7);
      look("ready_lookup0", 8'd0, 8'd0);

      stk = '{{8'd3, 8'd1}};
      run_frame(8'd4);
      chk("single_pops", pop_total - pops_start, 1);
      chk("single_nobj", n_objects, 2);
      look("single_l1", 8'd1, 8'd1);
      look("single_l2", 8'd2, 8'd2);
      look("single_l3", 8'd3, 8'd1);
      look("single_l5", 8'd5, 8'd5);
      do_clear();

      stk = '{{8'd4, 8'd3}, {8'd3, 8'd2}, {8'd2, 8'd1}};
      run_frame(8'd5);
      chk("chain_pops", pop_total - pops_start, 3);
      chk("chain_nobj", n_objects, 1);
      look("chain_l1", 8'd1, 8'd1);
      look("chain_l2", 8'd2, 8'd1);
      look("chain_l3", 8'd3, 8'd1);
      look("chain_l4", 8'd4, 8'd1);
      do_clear();

      stk = '{{8'd2, 8'd2}, {8'd5, 8'd0}, {8'd3, 8'd1}, {8'd3, 8'd1}};
      run_frame(8'd4);
      chk("degen_pops", pop_total - pops_start, 4);
      chk("degen_nobj", n_objects, 2);
      look("degen_l3", 8'd3, 8'd1);
      look("degen_l2", 8'd2, 8'd2);
      do_clear();

      run_frame(8'd6);
      chk("empty_pops", pop_total - pops_start, 0);
      chk("empty_cycles", cyc, 7);
      chk("empty_nobj", n_objects, 5);
      do_clear();

      stk = '{{8'd4, 8'd3}};
      num_labels = 8'd5;
      repeat (2) @(negedge clk);
      frame_done = 1'b1;
      @(posedge clk);
      #1;
      frame_done = 1'b0;
      chk("mid_drain_pop", pop, 1);
      @(posedge clk);
      #1;
      chk("mid_finda_pop", pop, 0);
      reset = 1'b1;
      #1;
      chk("mid_rst_pop", pop, 0);
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      wait_ready("mid");
      look("mid_l3", 8'd3, 8'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
